cheshire_cfg_reporter: RTL and testbench
========================================

CHESHIRE_CFG_REPORTER -- requirements
Module: cheshire_cfg_reporter

Interface
REQ-001 SHALL have parameter Cfg, default DefaultCfg; the Cheshire config exposed to software.
REQ-002 SHALL have parameter CfgIdx, default 0; the numeric config index reported to software.
REQ-003 SHALL have parameters reg_req_t and reg_rsp_t, default logic; the Regbus request and response types.
REQ-004 SHALL have port clk_i, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port reg_req_i, input, reg_req_t; the Regbus request (addr, write, wdata, wstrb, valid).
REQ-007 SHALL have port reg_rsp_o, output, reg_rsp_t; the Regbus response (rdata, error, ready).
REQ-008 SHALL have port eoc_valid_o, output, 1 bit; an end-of-computation exit code is pending.
REQ-009 SHALL have port eoc_code_o, output, 31 bits; the pending exit code.
REQ-010 SHALL have port eoc_ready_i, input, 1 bit; the bench consumes the exit code.

Function
REQ-011 SHALL decode addr[4:2] only; word map:
- 0x00 MAGIC: RO, 0x4348_5331.
- 0x04 CFG_IDX: RO.
- 0x08 FEATURES: RO; bit0 AxiRt, bit1 Ara, bit2 Uart, bit3 Vga, bit4 SerialLink, bit5 Dma, other bits 0.
- 0x0C ARA_NR_LANES: RO.
- 0x10 ARA_VLEN: RO.
- 0x14 SCRATCH: RW, honours wstrb.
- 0x18 READ_COUNT: RO.
- 0x1C EOC: WO.
REQ-012 SHALL use an FSM with three states:
- IDLE: valid seen -> capture addr/write/wdata/wstrb -> RESP.
- RESP: ready=1 for exactly one cycle with rdata/error -> IDLE.
- EOC_WAIT: entered from IDLE on an EOC write while eoc_valid_o=1; ready=0; -> RESP on the cycle eoc_ready_i=1.
REQ-013 SHALL give every access a latency of exactly one cycle from the first valid cycle to ready when no EOC stall applies; the initiator holds valid and payload until ready.
REQ-014 SHALL drive rdata=0 and error=0 whenever ready=0.
REQ-015 SHALL answer a write to an RO word with error=1 and no state change, and SHALL answer a read of EOC with error=1 and rdata=0.
REQ-016 SHALL increment READ_COUNT (16 bits, zero-extended) by one in the RESP cycle of each read of any word, saturating at 0xFFFF; the returned value is the pre-increment count.
REQ-017 SHALL set eoc_valid_o=1 and eoc_code_o=wdata[31:1] on an EOC write with wdata[0]=1; with wdata[0]=0 the write is accepted with no effect.
REQ-018 SHALL clear eoc_valid_o in the cycle after eoc_valid_o and eoc_ready_i are both 1.
REQ-019 SHALL, when a new EOC write coincides with the consuming handshake, accept the write in EOC_WAIT and load the new code in the following cycle, with no bubble in eoc_valid_o.
REQ-020 SHALL NOT register valid requests while in RESP; back-to-back accesses therefore occupy a minimum of two cycles each.

Reset
REQ-021 SHALL, on rst_ni low at any time including mid-transaction, go to IDLE and set ready=0, rdata=0, error=0, SCRATCH=0, READ_COUNT=0, eoc_valid_o=0 and eoc_code_o=0.
REQ-022 SHALL drop any captured request on reset; the initiator reissues it.

Configuration
REQ-023 SHALL gate the EOC feature with the macro CHESHIRE_CFG_REPORTER_EOC_EN.
- Defined: EOC behaves as REQ-017 to REQ-019.
- Undefined: EOC_WAIT is absent, any EOC access returns error=1, and eoc_valid_o and eoc_code_o are tied to 0; all ports remain present.

Structure
REQ-024 SHALL place the register offsets, the MAGIC constant and the FEATURES bit positions in tb_cheshire_pkg, next to TbCheshireConfigs.
REQ-025 SHALL be a single module with no sub-module; the FEATURES word is a function of Cfg in the package.

Verification
REQ-026 SHALL test with CfgIdx=2 and the Ara config: read 0x00, 0x04, 0x08, 0x0C, 0x10 -> 0x43485331, 2, 0x2 | Uart/Vga/SerialLink/Dma bits of the config, 2, 2048; each ready comes one cycle after valid.
REQ-027 SHALL test SCRATCH: write 0xDEADBEEF with wstrb=0b0101, then read -> 0x00AD00EF, error=0.
REQ-028 SHALL test READ_COUNT: do 3 reads of MAGIC, then read 0x18 -> 3; force the count to 0xFFFF, read twice -> the count stays 0xFFFF.
REQ-029 SHALL test EOC: write 0x1C with 0x3, hold eoc_ready_i=0 -> eoc_valid_o=1, code=1; a second EOC write with 0x5 stalls (ready=0); raise eoc_ready_i -> the write completes and code=2.
REQ-030 SHALL test errors: write 0x08 -> error=1 and FEATURES unchanged; read 0x1C -> error=1, rdata=0.
REQ-031 SHALL test reset: assert rst_ni low during RESP -> ready=0 immediately and all registers at reset values; build without the macro -> an EOC write returns error=1.

Source files
------------

// File: rtl/tb_cheshire_pkg.sv
// Cheshire configuration records plus the cfg reporter register map and FEATURES layout.
package tb_cheshire_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_bus_rsp_t;

  typedef struct packed {
    logic        axi_rt;
    logic        ara;
    logic        uart;
    logic        vga;
    logic        serial_link;
    logic        dma;
    logic [31:0] ara_nr_lanes;
    logic [31:0] ara_vlen;
  } cheshire_cfg_t;

  localparam cheshire_cfg_t DefaultCfg = '{
    axi_rt: 1'b0, ara: 1'b0, uart: 1'b1, vga: 1'b1, serial_link: 1'b1, dma: 1'b1,
    ara_nr_lanes: 32'd0, ara_vlen: 32'd0
  };

  localparam cheshire_cfg_t RtCfg = '{
    axi_rt: 1'b1, ara: 1'b0, uart: 1'b1, vga: 1'b0, serial_link: 1'b0, dma: 1'b1,
    ara_nr_lanes: 32'd0, ara_vlen: 32'd0
  };

  localparam cheshire_cfg_t AraCfg = '{
    axi_rt: 1'b0, ara: 1'b1, uart: 1'b1, vga: 1'b0, serial_link: 1'b1, dma: 1'b1,
    ara_nr_lanes: 32'd2, ara_vlen: 32'd2048
  };

  localparam cheshire_cfg_t TbCheshireConfigs [3] = '{DefaultCfg, RtCfg, AraCfg};

  localparam logic [4:0] OffMagic    = 5'h00;
  localparam logic [4:0] OffCfgIdx   = 5'h04;
  localparam logic [4:0] OffFeatures = 5'h08;
  localparam logic [4:0] OffLanes    = 5'h0C;
  localparam logic [4:0] OffVlen     = 5'h10;
  localparam logic [4:0] OffScratch  = 5'h14;
  localparam logic [4:0] OffReadCnt  = 5'h18;
  localparam logic [4:0] OffEoc      = 5'h1C;

  localparam logic [31:0] CfgMagic = 32'h4348_5331;

  localparam int unsigned FeatAxiRt      = 0;
  localparam int unsigned FeatAra        = 1;
  localparam int unsigned FeatUart       = 2;
  localparam int unsigned FeatVga        = 3;
  localparam int unsigned FeatSerialLink = 4;
  localparam int unsigned FeatDma        = 5;

  function automatic logic [31:0] cfg_features(cheshire_cfg_t cfg);
    logic [31:0] f;
    f                 = '0;
    f[FeatAxiRt]      = cfg.axi_rt;
    f[FeatAra]        = cfg.ara;
    f[FeatUart]       = cfg.uart;
    f[FeatVga]        = cfg.vga;
    f[FeatSerialLink] = cfg.serial_link;
    f[FeatDma]        = cfg.dma;
    return f;
  endfunction

endpackage

// File: rtl/cheshire_cfg_reporter_if.sv
// Regbus request/response bundle for the cfg reporter.
interface cheshire_cfg_reporter_if;
  import tb_cheshire_pkg::*;

  reg_bus_req_t req;
  reg_bus_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/cheshire_cfg_reporter.sv
// Regbus-visible Cheshire config report, scratch word, read counter and EOC exit-code mailbox.
// The EOC mailbox exists only when CHESHIRE_CFG_REPORTER_EOC_EN is defined.
module cheshire_cfg_reporter #(
  parameter tb_cheshire_pkg::cheshire_cfg_t Cfg = tb_cheshire_pkg::DefaultCfg,
  parameter int unsigned CfgIdx = 0,
  parameter type reg_req_t = tb_cheshire_pkg::reg_bus_req_t,
  parameter type reg_rsp_t = tb_cheshire_pkg::reg_bus_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  reg_req_t    reg_req_i,
  output reg_rsp_t    reg_rsp_o,
  output logic        eoc_valid_o,
  output logic [30:0] eoc_code_o,
  input  logic        eoc_ready_i
);
  import tb_cheshire_pkg::*;

  localparam logic [1:0] Idle    = 2'd0;
  localparam logic [1:0] Resp    = 2'd1;
  localparam logic [1:0] EocWait = 2'd2;

  localparam logic [2:0] IdxMagic    = OffMagic[4:2];
  localparam logic [2:0] IdxCfgIdx   = OffCfgIdx[4:2];
  localparam logic [2:0] IdxFeatures = OffFeatures[4:2];
  localparam logic [2:0] IdxLanes    = OffLanes[4:2];
  localparam logic [2:0] IdxVlen     = OffVlen[4:2];
  localparam logic [2:0] IdxScratch  = OffScratch[4:2];
  localparam logic [2:0] IdxReadCnt  = OffReadCnt[4:2];
  localparam logic [2:0] IdxEoc      = OffEoc[4:2];

  localparam logic [31:0] Features = cfg_features(Cfg);

`ifdef CHESHIRE_CFG_REPORTER_EOC_EN
  localparam bit EocEn = 1'b1;
`else
  localparam bit EocEn = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  cap_idx_q;
  logic        cap_write_q;
  logic [31:0] cap_wdata_q;
  logic [3:0]  cap_wstrb_q;
  logic [31:0] scratch_q;
  logic [15:0] read_cnt_q;
  logic        req_eoc_wr;
  logic        eoc_stall;
  logic        eoc_wait_done;
  logic        unused_addr;

  assign unused_addr = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0]};
  assign req_eoc_wr  = reg_req_i.valid && reg_req_i.write && (reg_req_i.addr[4:2] == IdxEoc);

`ifdef CHESHIRE_CFG_REPORTER_EOC_EN
  logic        eoc_valid_q;
  logic [30:0] eoc_code_q;
  logic        eoc_apply;
  logic [31:0] eoc_wdata;

  assign eoc_stall     = req_eoc_wr && eoc_valid_q;
  assign eoc_wait_done = (state_q == EocWait) && (eoc_ready_i || !eoc_valid_q);

  // A stalled write lands on the same edge as the consuming handshake, so the
  // new code replaces the old one without eoc_valid_o dropping in between.
  always_comb begin
    eoc_apply = 1'b0;
    eoc_wdata = reg_req_i.wdata;
    if (state_q == Idle && req_eoc_wr && !eoc_valid_q) begin
      eoc_apply = 1'b1;
    end else if (eoc_wait_done) begin
      eoc_apply = 1'b1;
      eoc_wdata = cap_wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eoc_valid_q <= 1'b0;
      eoc_code_q  <= '0;
    end else if (eoc_apply && eoc_wdata[0]) begin
      eoc_valid_q <= 1'b1;
      eoc_code_q  <= eoc_wdata[31:1];
    end else if (eoc_valid_q && eoc_ready_i) begin
      eoc_valid_q <= 1'b0;
    end
  end

  assign eoc_valid_o = eoc_valid_q;
  assign eoc_code_o  = eoc_code_q;
`else
  logic unused_eoc;

  assign unused_eoc    = eoc_ready_i;
  assign eoc_stall     = 1'b0;
  assign eoc_wait_done = 1'b0;
  assign eoc_valid_o   = 1'b0;
  assign eoc_code_o    = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (reg_req_i.valid) state_d = eoc_stall ? EocWait : Resp;
      EocWait: if (eoc_wait_done) state_d = Resp;
      Resp:    state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      cap_idx_q   <= '0;
      cap_write_q <= 1'b0;
      cap_wdata_q <= '0;
      cap_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == Idle && reg_req_i.valid) begin
        cap_idx_q   <= reg_req_i.addr[4:2];
        cap_write_q <= reg_req_i.write;
        cap_wdata_q <= reg_req_i.wdata;
        cap_wstrb_q <= reg_req_i.wstrb;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scratch_q  <= '0;
      read_cnt_q <= '0;
    end else if (state_q == Resp) begin
      if (cap_write_q && cap_idx_q == IdxScratch) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (cap_wstrb_q[b]) scratch_q[8*b +: 8] <= cap_wdata_q[8*b +: 8];
        end
      end
      if (!cap_write_q && read_cnt_q != '1) read_cnt_q <= read_cnt_q + 16'd1;
    end
  end

  always_comb begin
    reg_rsp_o = '0;
    if (state_q == Resp) begin
      reg_rsp_o.ready = 1'b1;
      if (cap_write_q) begin
        reg_rsp_o.error = !(cap_idx_q == IdxScratch || (EocEn && cap_idx_q == IdxEoc));
      end else begin
        case (cap_idx_q)
          IdxMagic:    reg_rsp_o.rdata = CfgMagic;
          IdxCfgIdx:   reg_rsp_o.rdata = 32'(CfgIdx);
          IdxFeatures: reg_rsp_o.rdata = Features;
          IdxLanes:    reg_rsp_o.rdata = Cfg.ara_nr_lanes;
          IdxVlen:     reg_rsp_o.rdata = Cfg.ara_vlen;
          IdxScratch:  reg_rsp_o.rdata = scratch_q;
          IdxReadCnt:  reg_rsp_o.rdata = {16'h0000, read_cnt_q};
          default:     reg_rsp_o.error = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cheshire_cfg_reporter.sv
// Self-checking bench for cheshire_cfg_reporter (Ara config, CfgIdx=2), both EOC build variants.
module tb_cheshire_cfg_reporter;
  import tb_cheshire_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc_valid;
  logic [30:0] eoc_code;
  logic        eoc_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  cheshire_cfg_reporter_if bus ();

  always #5 clk = ~clk;

  cheshire_cfg_reporter #(
    .Cfg       (TbCheshireConfigs[2]),
    .CfgIdx    (2),
    .reg_req_t (reg_bus_req_t),
    .reg_rsp_t (reg_bus_rsp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_req_i   (bus.req),
    .reg_rsp_o   (bus.rsp),
    .eoc_valid_o (eoc_valid),
    .eoc_code_o  (eoc_code),
    .eoc_ready_i (eoc_ready)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [4:0]  off;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] off, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    bus.req.addr  = {27'h0, off};
    bus.req.write = wr;
    bus.req.wdata = wdata;
    bus.req.wstrb = wstrb;
    bus.req.valid = 1'b1;
  endtask

  task automatic idle_bus();
    bus.req = '0;
  endtask

  // Waits up to budget cycles for ready, then pops the scoreboard and compares.
  task automatic finish_access(input string name, input int budget, input int exp_lat);
    exp_t e;
    int   lat = 0;
    for (int c = 1; c <= budget && lat == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp.ready) lat = c;
    end
    e = sb.pop_front();
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, budget);
    end else begin
      check({name, " rdata"}, bus.rsp.rdata, e.rdata);
      check({name, " error"}, {31'h0, bus.rsp.error}, {31'h0, e.err});
      check({name, " latency"}, lat, exp_lat);
    end
    idle_bus();
    @(negedge clk);
  endtask

  task automatic access(input string name, input logic [4:0] off, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err);
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    drive(off, wr, wdata, wstrb);
    finish_access(name, 10, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{off: OffMagic,    wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h4348_5331, exp_err: 1'b0};
    vecs[1]  = '{off: OffCfgIdx,   wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'd2,         exp_err: 1'b0};
    vecs[2]  = '{off: OffFeatures, wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h0000_0036, exp_err: 1'b0};
    vecs[3]  = '{off: OffLanes,    wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'd2,         exp_err: 1'b0};
    vecs[4]  = '{off: OffVlen,     wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'd2048,      exp_err: 1'b0};
    vecs[5]  = '{off: OffScratch,  wr: 1'b1, wdata: 32'hDEAD_BEEF, wstrb: 4'h5, exp_rdata: 32'h0,         exp_err: 1'b0};
    vecs[6]  = '{off: OffScratch,  wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h00AD_00EF, exp_err: 1'b0};
    vecs[7]  = '{off: OffFeatures, wr: 1'b1, wdata: 32'hFFFF_FFFF, wstrb: 4'hF, exp_rdata: 32'h0,         exp_err: 1'b1};
    vecs[8]  = '{off: OffFeatures, wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h0000_0036, exp_err: 1'b0};
    vecs[9]  = '{off: OffEoc,      wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h0,         exp_err: 1'b1};
    vecs[10] = '{off: OffReadCnt,  wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'd8,         exp_err: 1'b0};
    vecs[11] = '{off: OffReadCnt,  wr: 1'b1, wdata: 32'h1234_5678, wstrb: 4'hF, exp_rdata: 32'h0,         exp_err: 1'b1};
    vecs[12] = '{off: OffReadCnt,  wr: 1'b0, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'd9,         exp_err: 1'b0};

    idle_bus();
    repeat (3) @(negedge clk);
    check("reset ready", {31'h0, bus.rsp.ready}, 32'h0);
    check("reset rdata", bus.rsp.rdata, 32'h0);
    check("reset error", {31'h0, bus.rsp.error}, 32'h0);
    check("reset eoc_valid", {31'h0, eoc_valid}, 32'h0);
    check("reset eoc_code", {1'b0, eoc_code}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      access($sformatf("vec%0d", i), vecs[i].off, vecs[i].wr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

`ifdef CHESHIRE_CFG_REPORTER_EOC_EN
    access("eoc nop", OffEoc, 1'b1, 32'h0000_0000, 4'hF, 32'h0, 1'b0);
    check("eoc nop valid", {31'h0, eoc_valid}, 32'h0);
    access("eoc set", OffEoc, 1'b1, 32'h0000_0003, 4'hF, 32'h0, 1'b0);
    check("eoc set valid", {31'h0, eoc_valid}, 32'h1);
    check("eoc set code", {1'b0, eoc_code}, 32'd1);

    sb.push_back('{rdata: 32'h0, err: 1'b0});
    drive(OffEoc, 1'b1, 32'h0000_0005, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("eoc stall ready", {31'h0, bus.rsp.ready}, 32'h0);
      check("eoc stall error", {31'h0, bus.rsp.error}, 32'h0);
    end
    check("eoc stall code", {1'b0, eoc_code}, 32'd1);
    eoc_ready = 1'b1;
    finish_access("eoc stalled wr", 10, 1);
    eoc_ready = 1'b0;
    check("eoc reload valid", {31'h0, eoc_valid}, 32'h1);
    check("eoc reload code", {1'b0, eoc_code}, 32'd2);
    eoc_ready = 1'b1;
    @(negedge clk);
    eoc_ready = 1'b0;
    check("eoc consumed valid", {31'h0, eoc_valid}, 32'h0);
    access("eoc set2", OffEoc, 1'b1, 32'h0000_0009, 4'hF, 32'h0, 1'b0);
    check("eoc set2 code", {1'b0, eoc_code}, 32'd4);
`else
    access("eoc disabled wr", OffEoc, 1'b1, 32'h0000_0003, 4'hF, 32'h0, 1'b1);
    check("eoc disabled valid", {31'h0, eoc_valid}, 32'h0);
    check("eoc disabled code", {1'b0, eoc_code}, 32'h0);
`endif

    // Reset while the response is being presented.
    drive(OffMagic, 1'b0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("pre-reset ready", {31'h0, bus.rsp.ready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid reset ready", {31'h0, bus.rsp.ready}, 32'h0);
    check("mid reset rdata", bus.rsp.rdata, 32'h0);
    check("mid reset eoc_valid", {31'h0, eoc_valid}, 32'h0);
    check("mid reset eoc_code", {1'b0, eoc_code}, 32'h0);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) access("magic", OffMagic, 1'b0, 32'h0, 4'h0, 32'h4348_5331, 1'b0);
    access("read count 3", OffReadCnt, 1'b0, 32'h0, 4'h0, 32'd3, 1'b0);
    access("scratch after reset", OffScratch, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    access("read count 5", OffReadCnt, 1'b0, 32'h0, 4'h0, 32'd5, 1'b0);

    force dut.read_cnt_q = 16'hFFFF;
    #1;
    release dut.read_cnt_q;
    @(negedge clk);
    access("read count max", OffReadCnt, 1'b0, 32'h0, 4'h0, 32'h0000_FFFF, 1'b0);
    access("read count sat", OffReadCnt, 1'b0, 32'h0, 4'h0, 32'h0000_FFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
